// File: rtl/aibcr3aux_osc_meas_pkg.sv
// Shared types and defaults for the AIB aux oscillator measurement controller.
// The state encoding lives here so the top and any debug logic agree on it.
package aibcr3aux_osc_meas_pkg;

    localparam int WIN_W_DEF      = 8;
    localparam int RST_CYC_DEF    = 4;
    localparam int SETTLE_CYC_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_RUN     = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } meas_state_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aibcr3aux_osc_meas_tmr.sv
// Loadable down-counter that times the CLR, RUN and SETTLE phases.
// Loading N gives N+1 cycles before o_zero is seen in the following state.
module aibcr3aux_osc_meas_tmr
    import aibcr3aux_osc_meas_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/aibcr3aux_osc_meas_ctrl.sv
// Sequencer for the aux ring-oscillator DFT counter: clear, count for a window,
// let the enable sync settle, then capture and limit-check one tap or all eight.
module aibcr3aux_osc_meas_ctrl
    import aibcr3aux_osc_meas_pkg::*;
#(
    parameter int WIN_W      = WIN_W_DEF,
    parameter int RST_CYC    = RST_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sweep,
    input  logic [2:0]       cntr_sel,
    input  logic [WIN_W-1:0] win_len,
    input  logic [5:0]       lim_lo,
    input  logic [5:0]       lim_hi,
    input  logic [5:0]       cntr_code_in,
    output logic             testpin_enable,
    output logic             testpin_resetb,
    output logic [2:0]       counter,
    output logic             busy,
    output logic             done,
    output logic [5:0]       code_out,
    output logic [7:0]       fail_mask,
    output logic             pass
);

    localparam int TMR_W = max_i(WIN_W, max_i($clog2(RST_CYC + 1), $clog2(SETTLE_CYC + 1)));
    localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

    meas_state_t      r_state;
    meas_state_t      w_state_next;
    logic             r_sweep;
    logic [2:0]       r_counter;
    logic [WIN_W-1:0] r_win_len;
    logic [5:0]       r_lim_lo;
    logic [5:0]       r_lim_hi;
    logic [5:0]       r_code_out;
    logic [7:0]       r_fail_mask;
    logic             r_pass;

    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic             w_accept;
    logic             w_capture;
    logic             w_fail;
    logic [7:0]       w_mask_upd;
    logic [TMR_W-1:0] w_run_load;

    aibcr3aux_osc_meas_tmr #(
        .W(TMR_W)
    ) u_tmr (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // A zero-length window still runs the oscillator for one cycle.
    assign w_run_load = (r_win_len == '0) ? '0 : TMR_W'(r_win_len - WIN_W'(1));

    // Inverted limits need no special case: any code then misses one bound.
    assign w_fail = (cntr_code_in < r_lim_lo) || (cntr_code_in > r_lim_hi);

    always_comb begin
        w_mask_upd            = r_fail_mask;
        w_mask_upd[r_counter] = w_fail;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = RST_LOAD;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        if (abort && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        w_accept     = 1'b1;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = RST_LOAD;
                        w_state_next = ST_CLR;
                    end
                end
                ST_CLR: begin
                    if (w_tmr_zero) begin
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = w_run_load;
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tmr_zero) begin
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = SETTLE_LOAD;
                        w_state_next = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_zero) begin
                        w_state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    w_capture = 1'b1;
                    if (r_sweep && (r_counter != 3'd7)) begin
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = RST_LOAD;
                        w_state_next = ST_CLR;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE:  w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sweep     <= 1'b0;
            r_counter   <= 3'd0;
            r_win_len   <= '0;
            r_lim_lo    <= 6'd0;
            r_lim_hi    <= 6'd0;
            r_code_out  <= 6'd0;
            r_fail_mask <= 8'd0;
            r_pass      <= 1'b0;
        end else if (w_accept) begin
            r_sweep     <= sweep;
            r_counter   <= sweep ? 3'd0 : cntr_sel;
            r_win_len   <= win_len;
            r_lim_lo    <= lim_lo;
            r_lim_hi    <= lim_hi;
            r_fail_mask <= 8'd0;
            r_pass      <= 1'b0;
        end else if (w_capture) begin
            r_code_out  <= cntr_code_in;
            r_fail_mask <= w_mask_upd;
            if (w_state_next == ST_CLR) begin
                r_counter <= r_counter + 3'd1;
            end else begin
                r_pass <= (w_mask_upd == 8'd0);
            end
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign testpin_enable = (r_state == ST_RUN);
    assign testpin_resetb = (r_state == ST_RUN) || (r_state == ST_SETTLE) ||
                            (r_state == ST_CAPTURE) || (r_state == ST_DONE);
    assign counter        = r_counter;
    assign code_out       = r_code_out;
    assign fail_mask      = r_fail_mask;
    assign pass           = r_pass;

endmodule

// File: tb/tb_aibcr3aux_osc_meas_ctrl.sv
// Self-checking bench for aibcr3aux_osc_meas_ctrl: a timeline model derived from
// the phase lengths is compared every cycle, plus literal per-scenario expectations.
`timescale 1ns/1ps
module tb_aibcr3aux_osc_meas_ctrl;

    localparam int RST = 4;
    localparam int SET = 4;

    localparam int P_IDLE = 0;
    localparam int P_CLR  = 1;
    localparam int P_RUN  = 2;
    localparam int P_SET  = 3;
    localparam int P_CAP  = 4;
    localparam int P_DONE = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sweep = 1'b0;
    logic [2:0] cntr_sel = 3'd0;
    logic [7:0] win_len = 8'd0;
    logic [5:0] lim_lo = 6'd0;
    logic [5:0] lim_hi = 6'd0;
    logic [5:0] cntr_code_in;
    logic       testpin_enable, testpin_resetb, busy, done, pass;
    logic [2:0] counter;
    logic [5:0] code_out;
    logic [7:0] fail_mask;

    // Oscillator model: the DFT block presents the code of whichever tap is selected.
    logic [5:0] osc_code [8];
    assign cntr_code_in = osc_code[counter];

    aibcr3aux_osc_meas_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .sweep          (sweep),
        .cntr_sel       (cntr_sel),
        .win_len        (win_len),
        .lim_lo         (lim_lo),
        .lim_hi         (lim_hi),
        .cntr_code_in   (cntr_code_in),
        .testpin_enable (testpin_enable),
        .testpin_resetb (testpin_resetb),
        .counter        (counter),
        .busy           (busy),
        .done           (done),
        .code_out       (code_out),
        .fail_mask      (fail_mask),
        .pass           (pass)
    );

    always #5 clk = ~clk;

    int e = 0;
    always @(posedge clk) e <= e + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, e);
        end
    endtask

    // Model state: what the DUT's visible registers must hold in the next cycle.
    bit         m_active = 1'b0;
    int         m_t0 = 0;
    bit         m_sweep = 1'b0;
    int         m_sel = 0, m_win = 0, m_lo = 0, m_hi = 0;
    logic [5:0] m_code_out = 6'd0;
    logic [7:0] m_mask = 8'd0;
    bit         m_pass = 1'b0;
    bit         m_pass_valid = 1'b1;
    int         m_cnt_hold = 0;

    int obs_done_cnt = 0, obs_done_e = 0;
    int obs_en_cnt = 0, obs_en_first = 0, obs_en_last = 0;

    // Timeline: the cycle after start's edge t0 is offset 0; each tap spends
    // RST clear, max(win,1) run, SET settle and 1 capture cycle; DONE follows the last tap.
    always @(negedge clk) begin : cmp
        int  off, tlen, ntap, lwin, tap, p, ph, exp_cnt, code;
        bit  fail;
        if (!reset_n) begin
            m_active     = 1'b0;
            m_code_out   = 6'd0;
            m_mask       = 8'd0;
            m_pass       = 1'b0;
            m_pass_valid = 1'b1;
            m_cnt_hold   = 0;
        end
        ph      = P_IDLE;
        tap     = 0;
        exp_cnt = m_cnt_hold;
        lwin    = (m_win == 0) ? 1 : m_win;
        tlen    = RST + lwin + SET + 1;
        ntap    = m_sweep ? 8 : 1;
        if (m_active) begin
            off = e - m_t0;
            if (off > ntap * tlen) begin
                m_active = 1'b0;
            end else if (off == ntap * tlen) begin
                ph = P_DONE;
            end else begin
                tap = off / tlen;
                p   = off % tlen;
                if (p < RST)                   ph = P_CLR;
                else if (p < RST + lwin)       ph = P_RUN;
                else if (p < RST + lwin + SET) ph = P_SET;
                else                           ph = P_CAP;
                exp_cnt = m_sweep ? tap : m_sel;
            end
        end

        chk("busy", busy, (ph != P_IDLE));
        chk("done", done, (ph == P_DONE));
        chk("testpin_enable", testpin_enable, (ph == P_RUN));
        if (ph == P_IDLE || ph == P_CLR || ph == P_RUN || ph == P_SET)
            chk("testpin_resetb", testpin_resetb, (ph == P_RUN || ph == P_SET));
        chk("counter", counter, exp_cnt);
        chk("code_out", code_out, m_code_out);
        chk("fail_mask", fail_mask, m_mask);
        if (m_pass_valid) chk("pass", pass, m_pass);

        if (done === 1'b1) begin
            obs_done_cnt++;
            obs_done_e = e;
        end
        if (testpin_enable === 1'b1) begin
            if (obs_en_cnt == 0) obs_en_first = e;
            obs_en_cnt++;
            obs_en_last = e;
        end

        m_cnt_hold = exp_cnt;
        if (reset_n) begin
            if (abort && ph != P_IDLE) begin
                m_active = 1'b0;
            end else if (ph == P_CAP) begin
                code = int'(osc_code[exp_cnt]);
                fail = (code < m_lo) || (code > m_hi);
                m_code_out      = osc_code[exp_cnt];
                m_mask[exp_cnt] = fail;
                if (tap == ntap - 1) begin
                    m_pass       = (m_mask == 8'd0);
                    m_pass_valid = 1'b1;
                end
            end else if (ph == P_IDLE && start && !abort) begin
                m_active     = 1'b1;
                m_t0         = e + 1;
                m_sweep      = sweep;
                m_sel        = int'(cntr_sel);
                m_win        = int'(win_len);
                m_lo         = int'(lim_lo);
                m_hi         = int'(lim_hi);
                m_mask       = 8'd0;
                m_pass_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled at edge k; outputs seen after edge n belong to cycle n+1.
    task automatic launch(input bit sw, input int sel, input int win, input int lo,
                          input int hi, output int k);
        sweep    = sw;
        cntr_sel = sel[2:0];
        win_len  = win[7:0];
        lim_lo   = lo[5:0];
        lim_hi   = hi[5:0];
        obs_done_cnt = 0;
        obs_en_cnt   = 0;
        start = 1'b1;
        k = e + 1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && obs_done_cnt == 0; i++) step();
        chk({name, "_done_seen"}, obs_done_cnt, 1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 8; i++) osc_code[i] = 6'd0;

        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_counter", counter, 0);
        chk("rst_resetb", testpin_resetb, 0);
        chk("rst_pass", pass, 0);
        reset_n = 1'b1;
        step();

        osc_code[5] = 6'd30;
        launch(1'b0, 5, 10, 20, 40, k);
        wait_done("single");
        chk("single_lat", obs_done_e - k, 19);
        chk("single_en_first", obs_en_first - k, 4);
        chk("single_en_last", obs_en_last - k, 13);
        chk("single_en_cnt", obs_en_cnt, 10);
        chk("single_code", code_out, 30);
        chk("single_mask", fail_mask, 0);
        chk("single_pass", pass, 1);
        chk("single_cnt", counter, 5);
        $display("txn single: lat=%0d code_out=%0d mask=%b pass=%0d", obs_done_e - k, code_out, fail_mask, pass);

        osc_code[0] = 6'd10; osc_code[1] = 6'd25; osc_code[2] = 6'd30; osc_code[3] = 6'd45;
        osc_code[4] = 6'd20; osc_code[5] = 6'd40; osc_code[6] = 6'd39; osc_code[7] = 6'd0;
        launch(1'b1, 0, 3, 20, 40, k);
        wait_done("sweep");
        repeat (2) step();
        chk("sweep_lat", obs_done_e - k, 96);
        chk("sweep_mask", fail_mask, 8'b1000_1001);
        chk("sweep_pass", pass, 0);
        chk("sweep_cnt", counter, 7);
        chk("sweep_done_once", obs_done_cnt, 1);
        chk("sweep_en_cnt", obs_en_cnt, 24);
        $display("txn sweep: lat=%0d mask=%b pass=%0d", obs_done_e - k, fail_mask, pass);

        osc_code[2] = 6'd33;
        launch(1'b0, 2, 4, 33, 33, k);
        wait_done("edge_eq");
        chk("edge_eq_pass", pass, 1);
        chk("edge_eq_code", code_out, 33);
        $display("txn limit_equal: code_out=%0d pass=%0d", code_out, pass);

        osc_code[1] = 6'd30;
        launch(1'b0, 1, 4, 40, 20, k);
        wait_done("inv_lim");
        chk("inv_lim_pass", pass, 0);
        chk("inv_lim_mask", fail_mask, 8'b0000_0010);
        $display("txn limit_inverted: mask=%b pass=%0d", fail_mask, pass);

        osc_code[3] = 6'd25;
        launch(1'b0, 3, 0, 20, 40, k);
        wait_done("win0");
        chk("win0_lat", obs_done_e - k, 10);
        chk("win0_en_cnt", obs_en_cnt, 1);
        chk("win0_en_first", obs_en_first - k, 4);
        $display("txn win_len0: lat=%0d en_cycles=%0d", obs_done_e - k, obs_en_cnt);

        launch(1'b0, 4, 10, 20, 40, k);
        repeat (6) step();
        chk("abort_pre_en", testpin_enable, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_en", testpin_enable, 0);
        chk("abort_resetb", testpin_resetb, 0);
        chk("abort_code_keep", code_out, 25);
        repeat (25) step();
        chk("abort_no_done", obs_done_cnt, 0);
        $display("txn abort_run: busy=%0d done_pulses=%0d", busy, obs_done_cnt);

        obs_done_cnt = 0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        repeat (3) step();
        chk("start_abort_idle", busy, 0);
        chk("start_abort_no_done", obs_done_cnt, 0);
        $display("txn start_with_abort: busy=%0d", busy);

        osc_code[6] = 6'd50;
        launch(1'b0, 6, 5, 20, 40, k);
        repeat (10) step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_settle_en", testpin_enable, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_code", code_out, 0);
        chk("mid_rst_mask", fail_mask, 0);
        chk("mid_rst_cnt", counter, 0);
        chk("mid_rst_resetb", testpin_resetb, 0);
        chk("mid_rst_en", testpin_enable, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        launch(1'b0, 6, 5, 20, 40, k);
        wait_done("post_rst");
        chk("post_rst_lat", obs_done_e - k, 14);
        chk("post_rst_mask", fail_mask, 8'b0100_0000);
        chk("post_rst_pass", pass, 0);
        $display("txn reset_in_settle: lat=%0d mask=%b", obs_done_e - k, fail_mask);

        launch(1'b0, 2, 6, 20, 40, k);
        repeat (3) step();
        cntr_sel = 3'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("busy_start");
        repeat (2) step();
        chk("busy_start_lat", obs_done_e - k, 15);
        chk("busy_start_cnt", counter, 2);
        chk("busy_start_once", obs_done_cnt, 1);
        chk("busy_start_pass", pass, 1);
        $display("txn start_while_busy: lat=%0d counter=%0d", obs_done_e - k, counter);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aibcr3aux_osc_meas_ctrl.md
AIBCR3AUX_OSC_MEAS_CTRL -- requirements
Module: aibcr3aux_osc_meas_ctrl

Interface
REQ-001 SHALL have parameter WIN_W, default 8: width of the measurement-window length field.
REQ-002 SHALL have parameter RST_CYC, default 4: cycles the oscillator counter is held in reset before each window.
REQ-003 SHALL have parameter SETTLE_CYC, default 4: cycles waited after the window closes before capture (covers the enable 2-FF sync into the oscillator domain).
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports start  input  1 (one-cycle request) and abort  input  1 (synchronous cancel).
REQ-007 SHALL have ports sweep  input  1 (measure all 8 taps) and cntr_sel  input  3 (tap for a single measurement).
REQ-008 SHALL have ports win_len  input  WIN_W (window length in clk cycles), lim_lo  input  6 and lim_hi  input  6 (inclusive pass limits).
REQ-009 SHALL have port cntr_code_in  input  6: the oscillator 6-bit counter code.
REQ-010 SHALL have ports testpin_enable  output  1, testpin_resetb  output  1 and counter  output  3: drive the oscillator DFT block.
REQ-011 SHALL have ports busy  output  1, done  output  1, code_out  output  6, fail_mask  output  8 and pass  output  1.

Function
REQ-012 SHALL implement states IDLE, CLR, RUN, SETTLE, CAPTURE and DONE.
REQ-013 SHALL accept start only in IDLE; start SHALL be ignored in all other states.
REQ-014 On accept, SHALL latch the parameters: sweep; counter <= 0 if sweep, else cntr_sel; win_len and the limits. SHALL clear fail_mask and enter CLR.
REQ-015 CLR SHALL last RST_CYC cycles, with testpin_resetb=0 and testpin_enable=0.
REQ-016 RUN SHALL last max(win_len,1) cycles, with testpin_resetb=1 and testpin_enable=1; win_len=0 is treated as 1.
REQ-017 SETTLE SHALL last SETTLE_CYC cycles, with testpin_enable=0 and testpin_resetb=1.
REQ-018 CAPTURE SHALL last 1 cycle and SHALL do the following:
- code_out <= cntr_code_in;
- fail = (code < lim_lo) or (code > lim_hi), unsigned;
- fail_mask[counter] <= fail.
REQ-019 If lim_lo > lim_hi, every capture SHALL fail.
REQ-020 After CAPTURE in sweep mode with counter < 7, SHALL increment counter and re-enter CLR; otherwise SHALL enter DONE.
REQ-021 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-022 pass SHALL equal (fail_mask==0) and SHALL be valid from DONE until the next accepted start.
REQ-023 counter SHALL stay constant from CLR entry through CAPTURE of each tap.
REQ-024 Latency: start sampled at edge k SHALL give done=1 in cycle k+2+RST_CYC+max(win_len,1)+SETTLE_CYC; a sweep takes 8 times the per-tap middle portion.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 abort in any non-IDLE state SHALL take effect on the next edge:
- go to IDLE with testpin_enable=0 and testpin_resetb=0;
- no done pulse;
- code_out and fail_mask keep partial results.
REQ-027 abort asserted together with start in IDLE SHALL win; start is ignored.
REQ-028 In IDLE, testpin_resetb SHALL be 0 and testpin_enable SHALL be 0.

Reset
REQ-029 On reset_n=0, the block SHALL asynchronously enter IDLE.
REQ-030 Reset values SHALL be: testpin_enable=0, testpin_resetb=0, counter=0, busy=0, done=0, code_out=0, fail_mask=0, pass=0.
REQ-031 Reset asserted mid-measurement SHALL discard the measurement; after reset_n rises, the first start SHALL behave as from power-up.

Structure
REQ-032 The state encoding and the default values of WIN_W, RST_CYC and SETTLE_CYC SHALL live in the shared package aibcr3aux_osc_meas_pkg.
REQ-033 A single sub-module, aibcr3aux_osc_meas_tmr, SHALL provide the loadable down-counter used for the CLR, RUN and SETTLE durations.
REQ-034 SHALL instantiate no other sub-modules, and the top level SHALL contain no combinational path from cntr_code_in to any output.

Verification
REQ-035 Single measurement SHALL be covered:
- stimulus: defaults, win_len=10, cntr_sel=5, limits 20..40, code=30, start at edge k;
- required response: counter=5, testpin_enable high for cycles k+5..k+14, done at k+20, code_out=30, fail_mask=0, pass=1.
REQ-036 Sweep SHALL be covered:
- stimulus: sweep=1; codes per tap 10,25,30,45,20,40,39,0; limits 20..40;
- required response: counter steps 0..7, fail_mask=8'b1000_1001, pass=0, exactly one done pulse.
REQ-037 Boundary limits SHALL be covered:
- stimulus: code=lim_lo=lim_hi=33 -> required response: pass=1;
- stimulus: lim_lo=40, lim_hi=20, any code -> required response: pass=0.
REQ-038 win_len=0 SHALL be covered: required response is testpin_enable high for exactly 1 cycle, with done at k+11 for defaults.
REQ-039 Abort SHALL be covered:
- stimulus: abort during RUN -> required response: next cycle IDLE, testpin_resetb=0, testpin_enable=0, no done, busy=0;
- stimulus: start+abort together in IDLE -> required response: stays IDLE.
REQ-040 Reset and busy start SHALL be covered:
- stimulus: reset_n pulsed low during SETTLE -> required response: all outputs at reset values immediately, and a subsequent start completes normally;
- stimulus: start during busy -> required response: ignored.
